// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: data width, receiver FSM state encoding and the
// clocks-per-bit helper used to size the baud counter.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_e;

  // Number of system clock cycles per serial bit (integer division).
  function automatic int bps_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_bps_module.sv
// -----------------------------------------------------------------------------
// rx_bps_module
// Baud counter for the UART receiver. Counts 0..BPS_DIV-1 while count_en is
// high and raises BPS_Strobe for one cycle when the count sits at BPS_DIV/2,
// i.e. in the middle of each bit period measured from the last clear.
// Ports:
//   CLK, RSTn   clock, asynchronous active-low reset
//   count_en    advance the counter this cycle
//   clear       restart the counter at 0 (wins over count_en)
//   BPS_Strobe  registered mid-bit sample strobe
// -----------------------------------------------------------------------------
module rx_bps_module #(
  parameter int BPS_DIV = 5208
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic count_en,
  input  logic clear,
  output logic BPS_Strobe
);

  localparam int CNT_W = $clog2(BPS_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BPS_DIV / 2);

  logic [CNT_W-1:0] count_d, count_q;
  logic             strobe_d, strobe_q;

  // Next count and strobe; the strobe is computed from the next count so the
  // registered strobe is high exactly while count_q equals the half-bit value.
  always_comb begin
    count_d  = count_q;
    strobe_d = 1'b0;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (count_en) begin
      if (count_q == CNT_MAX) begin
        count_d = {CNT_W{1'b0}};
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      strobe_d = (count_d == CNT_HALF);
    end else begin
      count_d = count_q;
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count_q  <= {CNT_W{1'b0}};
      strobe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

  assign BPS_Strobe = strobe_q;

endmodule

// File: rtl/uart_rx_function_module.sv
// -----------------------------------------------------------------------------
// uart_rx_function_module
// 8N1 UART receiver, LSB first. The raw line is synchronised, a 1->0 edge
// while enabled starts a frame, each bit is sampled at mid-bit and a good
// stop bit publishes the byte. A low stop bit reports a framing error.
// Ports:
//   CLK, RSTn    clock, asynchronous active-low reset
//   RX_Pin_In    raw serial line (idle high, asynchronous)
//   RX_En_Sig    receive enable; dropping it mid-frame aborts the frame
//   RX_Data      last correctly framed byte
//   RX_Done_Sig  one-cycle pulse, RX_Data updated this cycle
//   RX_Err_Sig   one-cycle pulse, stop bit sampled low
//   RX_Busy      high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_function_module
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   RX_Pin_In,
  input  logic                   RX_En_Sig,
  output logic [UART_DATA_W-1:0] RX_Data,
  output logic                   RX_Done_Sig,
  output logic                   RX_Err_Sig,
  output logic                   RX_Busy
);

  localparam int BPS_DIV = bps_div(CLK_FREQ, BAUD);

  rx_state_e state_d, state_q;
  logic [2:0]             idx_d, idx_q;
  logic [UART_DATA_W-1:0] shift_d, shift_q;
  logic [UART_DATA_W-1:0] data_d, data_q;
  logic                   done_d, done_q;
  logic                   err_d, err_q;
  logic                   busy_d, busy_q;
  logic                   sync1_q, sync2_q, hist_q;

  logic line_s;
  logic fall_s;
  logic clear_s;
  logic count_en_s;
  logic strobe_s;

  // Two-stage synchroniser plus one history stage for edge detection.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= RX_Pin_In;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign line_s     = sync2_q;
  assign fall_s     = hist_q & ~sync2_q;
  assign count_en_s = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);

  rx_bps_module #(
    .BPS_DIV (BPS_DIV)
  ) u_bps (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .count_en   (count_en_s),
    .clear      (clear_s),
    .BPS_Strobe (strobe_s)
  );

  // Receiver FSM: next state, shift register, bit index and output pulses.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RX_En_Sig && fall_s) begin
          state_d = ST_START;
          clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!RX_En_Sig) begin
          state_d = ST_IDLE;
        end else if (strobe_s) begin
          // A line that is high again at mid start bit was only a glitch.
          if (!line_s) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (!RX_En_Sig) begin
          state_d = ST_IDLE;
        end else if (strobe_s) begin
          shift_d[idx_q] = line_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (!RX_En_Sig) begin
          state_d = ST_IDLE;
        end else if (strobe_s) begin
          // Leaving at mid stop bit leaves half a bit to catch the next start.
          if (line_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DONE: begin
        data_d  = shift_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      shift_q <= {UART_DATA_W{1'b0}};
      data_q  <= {UART_DATA_W{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign RX_Err_Sig  = err_q;
  assign RX_Busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_function_module.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_function_module
// Scoreboard bench: each transmitted frame pushes the response the line
// protocol implies (byte on good stop, error with old byte on bad stop,
// nothing when disabled); an independent monitor pops on every pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx_function_module;

  localparam int B = 10;  // 1 MHz / 100 kbaud

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       pin;
  logic       en;
  logic [7:0] rx_data;
  logic       done;
  logic       err;
  logic       busy;

  exp_t       q[$];
  exp_t       mon_e;
  int         mon_lat;
  int         cyc;
  int         tests;
  int         fails;
  logic [7:0] last_good;
  int         busy_cnt;

  uart_rx_function_module #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .CLK         (clk),
    .RSTn        (rst_n),
    .RX_Pin_In   (pin),
    .RX_En_Sig   (en),
    .RX_Data     (rx_data),
    .RX_Done_Sig (done),
    .RX_Err_Sig  (err),
    .RX_Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Busy-cycle counter, cleared by the stimulus around windows of interest.
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  // Monitor: every Done/Err pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && err) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL excl: done=%0b err=%0b, required not both high", done, err);
      end
      if (done || err) begin
        tests = tests + 1;
        if (q.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_pulse: done=%0b err=%0b data=%02h at cyc %0d, required no pulse",
                   done, err, rx_data, cyc);
        end else begin
          mon_e   = q.pop_front();
          mon_lat = cyc - mon_e.start_cyc;
          if (done !== !mon_e.is_err || err !== mon_e.is_err || rx_data !== mon_e.data ||
              mon_lat < (mon_e.is_err ? 97 : 99) || mon_lat > 101) begin
            fails = fails + 1;
            $display("FAIL frame: done=%0b err=%0b data=%02h lat=%0d, required done=%0b err=%0b data=%02h lat~%0d",
                     done, err, rx_data, mon_lat, !mon_e.is_err, mon_e.is_err, mon_e.data,
                     mon_e.is_err ? 99 : 100);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Hold one bit level for a full bit time; called and returns on a negedge.
  task automatic drive_bit(input logic v);
    pin = v;
    repeat (B) @(negedge clk);
  endtask

  task automatic idle(input int n);
    pin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // drop_bit >= 0 lowers the enable just before that data bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int drop_bit,
                            input bit expect_resp);
    exp_t e;
    if (expect_resp) begin
      e.is_err    = !stop_ok;
      e.data      = stop_ok ? b : last_good;
      e.start_cyc = cyc;
      q.push_back(e);
      if (stop_ok) last_good = b;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_bit) en = 1'b0;
      drive_bit(b[i]);
    end
    drive_bit(stop_ok ? 1'b1 : 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    bit         ok;
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    busy_cnt  = 0;
    last_good = 8'h00;
    pin       = 1'b1;
    en        = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_flags", {29'd0, done, err, busy}, 32'h0);
    rst_n = 1'b1;
    idle(20);

    // Single byte.
    send_frame(8'hA5, 1'b1, -1, 1'b1);
    idle(20);
    check("a5_data", {24'd0, rx_data}, 32'hA5);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, -1, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 1'b1);
    idle(20);
    check("b2b_data", {24'd0, rx_data}, 32'hFF);

    // Framing error, line then held low: no new frame until a real edge.
    send_frame(8'h3C, 1'b0, -1, 1'b1);
    repeat (30) @(negedge clk);
    idle(20);
    check("err_keeps_data", {24'd0, rx_data}, 32'hFF);
    check("err_pending", q.size(), 32'd0);

    // Three-cycle glitch on the idle line.
    busy_cnt = 0;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_busy_pulse", (busy_cnt >= 4 && busy_cnt <= 10) ? 32'd1 : 32'd0, 32'd1);
    check("glitch_data", {24'd0, rx_data}, 32'hFF);

    // Receiver disabled for the whole frame.
    en = 1'b0;
    busy_cnt = 0;
    idle(5);
    send_frame(8'h81, 1'b1, -1, 1'b0);
    idle(10);
    check("disabled_busy", busy_cnt, 32'd0);
    en = 1'b1;
    idle(10);

    // Enable dropped at data bit 4.
    send_frame(8'h96, 1'b1, 4, 1'b0);
    check("drop_busy", {31'd0, busy}, 32'd0);
    idle(10);
    en = 1'b1;
    idle(10);
    check("drop_data", {24'd0, rx_data}, 32'hFF);

    // Asynchronous reset in the middle of a frame.
    pin = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h5A >> i));
    rst_n = 1'b0;
    #1;
    check("midreset_data", {24'd0, rx_data}, 32'h00);
    check("midreset_flags", {29'd0, done, err, busy}, 32'h0);
    last_good = 8'h00;
    @(negedge clk);
    idle(10);
    rst_n = 1'b1;
    idle(10);
    send_frame(8'h12, 1'b1, -1, 1'b1);
    idle(20);
    check("after_reset_data", {24'd0, rx_data}, 32'h12);

    // Randomised frames with occasional bad stop bits and random gaps.
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(rb, ok, -1, 1'b1);
      idle(ok ? int'($urandom_range(0, 12)) : 10 + int'($urandom_range(0, 5)));
    end
    idle(40);
    check("final_data", {24'd0, rx_data}, {24'd0, last_good});
    check("final_pending", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
